data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, giving the number of 32-bit words in the internal data array.
REQ-002 SHALL have parameter ADDR_W, default 32, giving the byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  request present.
REQ-006 SHALL have port req_ready_o  output  1  responder can accept a request.
REQ-007 SHALL have port req_addr_i  input  ADDR_W  byte address.
REQ-008 SHALL have port req_wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port req_op_i  input  MEM_WIDTH_CODE  access code (lb/lbu/lh/lhu/lw/sb/sh/sw) from mem_control_pkg.
REQ-010 SHALL have port rsp_valid_o  output  1  response present.
REQ-011 SHALL have port rsp_ready_i  input  1  requester accepts response.
REQ-012 SHALL have port rsp_rdata_o  output  32  load result, extended; 0 for stores and errors.
REQ-013 SHALL have port rsp_err_o  output  1  misaligned or out-of-range access.

Function
REQ-014 SHALL implement an FSM with states IDLE, READ, RESP.
REQ-015 SHALL drive req_ready_o = 1 only in IDLE; a request is accepted on a cycle with req_valid_i && req_ready_o.
REQ-016 SHALL flag an error when: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0; or word index addr[ADDR_W-1:2] >= DEPTH.
REQ-017 On an accepted error request, SHALL not access the array and SHALL go IDLE->RESP with rsp_err_o=1, rsp_rdata_o=0.
REQ-018 On an accepted legal store, SHALL write the array in the accept cycle and go IDLE->RESP with rsp_err_o=0, rsp_rdata_o=0.
REQ-019 Store byte lanes: sb writes lane addr[1:0] with wdata[7:0]; sh writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; sw writes all four lanes; unwritten lanes unchanged.
REQ-020 On an accepted legal load, SHALL capture addr[1:0] and op, issue a synchronous array read, and go IDLE->READ->RESP.
REQ-021 Load formatting in READ->RESP: lb/lbu select lane addr[1:0]; lh/lhu select half addr[1]; lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
REQ-022 Latency: store/error response valid 1 cycle after accept; load response valid 2 cycles after accept.
REQ-023 In RESP, SHALL hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable until rsp_valid_o && rsp_ready_i, then go to IDLE.
REQ-024 SHALL NOT accept a new request in the RESP-exit cycle (ready rises the following cycle).
REQ-025 SHALL ignore req_* inputs in READ and RESP.

Reset
REQ-026 When rst_n=0 at a rising edge: state=IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0; req_ready_o=1 from the first cycle after reset.
REQ-027 Reset SHALL NOT clear array contents; a store written before reset persists.
REQ-028 Reset during READ or RESP SHALL discard the pending response without emitting it.

Structure
REQ-029 Access codes and MEM_WIDTH_CODE SHALL come from mem_control_pkg; the FSM state enum SHALL be added there as a typedef.
REQ-030 Array SHALL be a sub-module data_mem_bram (synchronous read, per-byte write enable, 1 cycle read latency); lane steering and extension stay in data_mem_responder.

Verification
REQ-031 sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> store rsp 1 cycle after accept (err=0, rdata=0); load rsp 2 cycles after accept with 0xDEADBEEF.
REQ-032 sb 0x13 data 0x80 over word 0x00000000, then lb 0x13 / lbu 0x13 / lw 0x10 -> 0xFFFFFF80 / 0x00000080 / 0x80000000.
REQ-033 sh 0x22 data 0x8001, then lh 0x22 / lhu 0x22 -> 0xFFFF8001 / 0x00008001; lh 0x21 -> err=1, rdata=0; sw 0x22 -> err=1, array unchanged.
REQ-034 lw with word index = DEPTH -> err=1, rdata=0, no array access.
REQ-035 Load response with rsp_ready_i held low 5 cycles -> rsp_valid/rdata/err stable throughout; req_ready_o=0 until 1 cycle after handshake.
REQ-036 Assert rst_n=0 in READ of lw 0x10 -> no rsp_valid_o after reset; subsequent lw 0x10 returns the pre-reset stored 0xDEADBEEF.

Source files
------------

// File: rtl/mem_control_pkg.sv
// Shared access codes, responder FSM states and the byte-lane helpers
// used by the data memory responder.
package mem_control_pkg;

    typedef enum logic [2:0] {
        MEM_LB  = 3'd0,
        MEM_LBU = 3'd1,
        MEM_LH  = 3'd2,
        MEM_LHU = 3'd3,
        MEM_LW  = 3'd4,
        MEM_SB  = 3'd5,
        MEM_SH  = 3'd6,
        MEM_SW  = 3'd7
    } MEM_WIDTH_CODE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } rsp_state_e;

    function automatic logic is_store(input MEM_WIDTH_CODE op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic misaligned(input MEM_WIDTH_CODE op, input logic [1:0] lo);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return lo[0];
            MEM_LW, MEM_SW:          return lo != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input MEM_WIDTH_CODE op, input logic [1:0] lo);
        case (op)
            MEM_SB:  return 4'b0001 << lo;
            MEM_SH:  return lo[1] ? 4'b1100 : 4'b0011;
            MEM_SW:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Right-aligned store data is replicated so every lane carries the value.
    function automatic logic [31:0] store_data(input MEM_WIDTH_CODE op, input logic [31:0] wdata);
        case (op)
            MEM_SB:  return {4{wdata[7:0]}};
            MEM_SH:  return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [31:0] word, input logic [1:0] lo,
                                                input MEM_WIDTH_CODE op);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (op)
            MEM_LB:  return {{24{b[7]}}, b};
            MEM_LBU: return {24'h000000, b};
            MEM_LH:  return {{16{h[15]}}, h};
            MEM_LHU: return {16'h0000, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_bram.sv
// Word-organised data array: synchronous read with one cycle latency and
// per-byte write enables. Contents have no reset.
module data_mem_bram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic          re_i,
    input  logic [3:0]    we_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder in front of a byte-writable array.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
module data_mem_responder
    import mem_control_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  MEM_WIDTH_CODE     req_op_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int AW = $clog2(DEPTH);

    rsp_state_e    state_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;
    logic [1:0]    lane_q;
    MEM_WIDTH_CODE op_q;

    logic              accept;
    logic              out_of_range;
    logic              req_err;
    logic              req_store;
    logic [ADDR_W-1:0] word_idx;
    logic [3:0]        bram_we;
    logic              bram_re;
    logic [31:0]       bram_rdata;

    assign word_idx     = {2'b00, req_addr_i[ADDR_W-1:2]};
    assign out_of_range = word_idx >= ADDR_W'(DEPTH);
    assign req_err      = out_of_range || misaligned(req_op_i, req_addr_i[1:0]);
    assign req_store    = is_store(req_op_i);
    assign accept       = rst_n && req_valid_i && (state_q == ST_IDLE);

    // Errored requests never reach the array, for reads or writes.
    assign bram_we = (accept && !req_err && req_store) ? store_mask(req_op_i, req_addr_i[1:0]) : 4'b0000;
    assign bram_re = accept && !req_err && !req_store;

    data_mem_bram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bram (
        .clk     (clk),
        .addr_i  (req_addr_i[AW+1:2]),
        .re_i    (bram_re),
        .we_i    (bram_we),
        .wdata_i (store_data(req_op_i, req_wdata_i)),
        .rdata_o (bram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            lane_q      <= 2'b00;
            op_q        <= MEM_LW;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_err || req_store) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                            rsp_err_q   <= req_err;
                        end else begin
                            state_q <= ST_READ;
                            lane_q  <= req_addr_i[1:0];
                            op_q    <= req_op_i;
                        end
                    end
                end
                ST_READ: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= load_format(bram_rdata, lane_q, op_q);
                    rsp_err_q   <= 1'b0;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, multi-cycle reset and
// back-pressure sequences, then random traffic against a byte-array model.
module tb_data_mem_responder;
    import mem_control_pkg::*;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;

    logic          clk;
    logic          rst_n;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [31:0]   req_addr_i;
    logic [31:0]   req_wdata_i;
    MEM_WIDTH_CODE req_op_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;

    int n_cmp  = 0;
    int n_fail = 0;

    data_mem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_op_i    (req_op_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        MEM_WIDTH_CODE op;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] ref_mem [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input MEM_WIDTH_CODE op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    // One full transaction, entered and left on a falling edge. While the
    // response is pending, a conflicting store to 0x10 is left on the request
    // bus; it must be ignored.
    task automatic xact(input MEM_WIDTH_CODE op, input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall, output logic [31:0] rd, output logic er, output int lat);
        int guard;
        req_op_i = op; req_addr_i = addr; req_wdata_i = wdata; req_valid_i = 1'b1;
        guard = 0;
        while (!req_ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        rd = 32'h0; er = 1'b1; lat = 99;
        if (!req_ready_o) begin
            n_cmp++; n_fail++;
            $display("FAIL req_ready_timeout: req_ready_o stayed 0 for %0d cycles", guard);
            req_valid_i = 1'b0;
            return;
        end
        @(negedge clk);
        req_op_i = MEM_SW; req_addr_i = 32'h10; req_wdata_i = ~wdata;
        lat = 1;
        while (!rsp_valid_o && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid_o) begin
            n_cmp++; n_fail++;
            $display("FAIL rsp_valid_timeout: no response after %0d cycles", lat);
            req_valid_i = 1'b0;
            lat = 99;
            return;
        end
        rd = rsp_rdata_o; er = rsp_err_o;
        for (int s = 0; s < stall; s++) begin
            rsp_ready_i = 1'b0;
            @(negedge clk);
            check("stall_valid", {31'b0, rsp_valid_o}, 32'h1);
            check("stall_rdata", rsp_rdata_o, rd);
            check("stall_err",   {31'b0, rsp_err_o}, {31'b0, er});
            check("stall_ready", {31'b0, req_ready_o}, 32'h0);
        end
        check("resp_ready_low", {31'b0, req_ready_o}, 32'h0);
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b0;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check("post_hs_valid", {31'b0, rsp_valid_o}, 32'h0);
        check("post_hs_ready", {31'b0, req_ready_o}, 32'h1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(v.op, v.addr, v.wdata, 0, rd, er, lat);
        check($sformatf("vec%0d_rdata", idx), rd, v.exp_rdata);
        check($sformatf("vec%0d_err", idx), {31'b0, er}, {31'b0, v.exp_err});
        check($sformatf("vec%0d_lat", idx), 32'(lat), 32'(v.exp_lat));
    endtask

    // Reference: little-endian byte memory, size from the access code.
    task automatic model(input MEM_WIDTH_CODE op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er, output int lat);
        int size;
        logic sgn;
        logic st;
        size = (op == MEM_LB || op == MEM_LBU || op == MEM_SB) ? 1 :
               (op == MEM_LH || op == MEM_LHU || op == MEM_SH) ? 2 : 4;
        sgn  = (op == MEM_LB || op == MEM_LH);
        st   = (op == MEM_SB || op == MEM_SH || op == MEM_SW);
        er   = ((addr % size) != 0) || ((addr / 4) >= DEPTH);
        rd   = 32'h0;
        lat  = (er || st) ? 1 : 2;
        if (er) return;
        if (st) begin
            for (int k = 0; k < size; k++) ref_mem[addr + k] = wdata[8*k +: 8];
        end else begin
            for (int k = 0; k < size; k++) rd = rd | (32'(ref_mem[addr + k]) << (8*k));
            if (sgn && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8*size));
        end
    endtask

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          lat, exp_lat, seen;

        rst_n = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
        req_addr_i = 32'h0; req_wdata_i = 32'h0; req_op_i = MEM_LW;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_ready", {31'b0, req_ready_o}, 32'h1);
        check("reset_valid", {31'b0, rsp_valid_o}, 32'h0);
        check("reset_rdata", rsp_rdata_o, 32'h0);
        check("reset_err",   {31'b0, rsp_err_o}, 32'h0);

        add_vec(MEM_SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1);
        add_vec(MEM_LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2);
        add_vec(MEM_SW,  32'h10, 32'h0,        32'h0,        1'b0, 1);
        add_vec(MEM_SB,  32'h13, 32'h80,       32'h0,        1'b0, 1);
        add_vec(MEM_LB,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 2);
        add_vec(MEM_LBU, 32'h13, 32'h0,        32'h00000080, 1'b0, 2);
        add_vec(MEM_LW,  32'h10, 32'h0,        32'h80000000, 1'b0, 2);
        add_vec(MEM_SW,  32'h20, 32'h0,        32'h0,        1'b0, 1);
        add_vec(MEM_SH,  32'h22, 32'h8001,     32'h0,        1'b0, 1);
        add_vec(MEM_LH,  32'h22, 32'h0,        32'hFFFF8001, 1'b0, 2);
        add_vec(MEM_LHU, 32'h22, 32'h0,        32'h00008001, 1'b0, 2);
        add_vec(MEM_LH,  32'h21, 32'h0,        32'h0,        1'b1, 1);
        add_vec(MEM_SW,  32'h22, 32'hFFFFFFFF, 32'h0,        1'b1, 1);
        add_vec(MEM_LW,  32'h20, 32'h0,        32'h80010000, 1'b0, 2);
        add_vec(MEM_LB,  32'h22, 32'h0,        32'h00000001, 1'b0, 2);
        add_vec(MEM_LB,  32'h23, 32'h0,        32'hFFFFFF80, 1'b0, 2);
        add_vec(MEM_LW,  32'h12, 32'h0,        32'h0,        1'b1, 1);
        add_vec(MEM_LW,  DEPTH*4, 32'h0,       32'h0,        1'b1, 1);
        add_vec(MEM_SB,  DEPTH*4 + 3, 32'h55,  32'h0,        1'b1, 1);
        add_vec(MEM_LW,  DEPTH*4 - 4, 32'h0,   32'h0,        1'b0, 2);
        add_vec(MEM_SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1);
        // Word DEPTH-1 is written first so the last in-range load reads known data.
        vecs.insert(19, '{MEM_SW, DEPTH*4 - 4, 32'h0, 32'h0, 1'b0, 1});

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Back-pressure: load held for 5 cycles with rsp_ready_i low.
        xact(MEM_LW, 32'h10, 32'h0, 5, rd, er, lat);
        check("stall_load_rdata", rd, 32'hDEADBEEF);
        check("stall_load_lat", 32'(lat), 32'd2);

        // Reset while in READ discards the response; array contents survive.
        req_op_i = MEM_LW; req_addr_i = 32'h10; req_valid_i = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid_o) seen++;
            @(negedge clk);
        end
        check("rst_read_no_rsp", 32'(seen), 32'd0);
        check("rst_read_ready", {31'b0, req_ready_o}, 32'h1);

        // Reset while in RESP with the response pending.
        req_op_i = MEM_LW; req_addr_i = 32'h10; req_valid_i = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_resp_pending", {31'b0, rsp_valid_o}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_resp_dropped", {31'b0, rsp_valid_o}, 32'h0);
        check("rst_resp_rdata", rsp_rdata_o, 32'h0);

        xact(MEM_LW, 32'h10, 32'h0, 0, rd, er, lat);
        check("post_rst_rdata", rd, 32'hDEADBEEF);
        check("post_rst_err", {31'b0, er}, 32'h0);

        // Random traffic over words 0..15 plus out-of-range addresses.
        for (int w = 0; w < 16; w++) begin
            model(MEM_SW, 32'(w*4), 32'h0, exp_rd, exp_er, exp_lat);
            xact(MEM_SW, 32'(w*4), 32'h0, 0, rd, er, lat);
        end
        for (int t = 0; t < 200; t++) begin
            MEM_WIDTH_CODE op;
            logic [31:0] addr, wdata;
            op    = MEM_WIDTH_CODE'(3'($urandom_range(0, 7)));
            wdata = $urandom;
            if ($urandom_range(0, 7) == 0)
                addr = ($urandom_range(0, 1) == 0) ? 32'(DEPTH*4 + $urandom_range(0, 255))
                                                   : ($urandom | 32'h8000_0000);
            else
                addr = 32'($urandom_range(0, 63));
            model(op, addr, wdata, exp_rd, exp_er, exp_lat);
            xact(op, addr, wdata, $urandom_range(0, 2), rd, er, lat);
            check($sformatf("rand%0d_rdata", t), rd, exp_rd);
            check($sformatf("rand%0d_err", t), {31'b0, er}, {31'b0, exp_er});
            check($sformatf("rand%0d_lat", t), 32'(lat), 32'(exp_lat));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
